seq_detector_param: RTL

- Parametrised Mealy sequence detector; next generation of the fixed-pattern top_seq detector.
- Bits are entered as two strobe inputs: input_0 means bit 0, input_1 means bit 1. Both are level signals from the VIO or buttons, so the block synchronises them and detects their edges internally.
- Pattern, pattern length and overlap mode are configurable.
- Adds a saturating match counter and a conflict error pulse.
- Sits under the VIO wrapper in place of top_seq.

---
 rtl/seq_detector_param.sv | 117 +++++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// ==== seq_detector_param : parametrised Mealy sequence detector (sync + edge strobes,
// ==== KMP-style next state, saturating match counter, conflict error)   Rev 1.0
`default_nettype none

module seq_detector_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 CNT_W   = 8,
  parameter int                 STATE_W = $clog2(PAT_LEN + 1)
) (
  input  logic               clk_100M,
  input  logic               clear,
  input  logic               input_0,
  input  logic               input_1,
  input  logic               overlap_en,
  output logic               out,
  output logic [STATE_W-1:0] present_state,
  output logic [CNT_W-1:0]   match_count,
  output logic               err
);

  // Pattern bit at prefix position idx; position 0 is the first bit received.
  function automatic logic pbit(input int idx);
    logic [PAT_LEN-1:0] t;
    t = PATTERN >> (PAT_LEN - 1 - idx);
    return t[0];
  endfunction

  function automatic int border();
    int   best;
    logic ok;
    best = 0;
    for (int l = 1; l < PAT_LEN; l++) begin
      ok = 1'b1;
      for (int j = 0; j < l; j++)
        if (pbit(j) != pbit(PAT_LEN - l + j)) ok = 1'b0;
      if (ok) best = l;
    end
    return best;
  endfunction

  // The last s accepted bits equal prefix_s, so candidate k needs
  // prefix_s[s-k+1 .. s-1] == prefix[0 .. k-2] and b == prefix[k-1].
  function automatic int next_len(input int s, input logic b);
    int   best;
    logic ok;
    best = 0;
    for (int k = 1; k <= PAT_LEN; k++) begin
      if (k <= s + 1) begin
        ok = (b == pbit(k - 1));
        for (int j = 0; j < k - 1; j++)
          if (pbit(s - k + 1 + j) != pbit(j)) ok = 1'b0;
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  localparam logic [STATE_W-1:0] c_BORDER = STATE_W'(border());

  logic [1:0]         sync1_q, sync2_q, prev_q;
  logic [1:0]         stb;
  int                 k;
  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_q, out_d;
  logic               err_q, err_d;

  assign stb = sync2_q & ~prev_q;

  always_comb begin
    k       = next_len(int'(state_q), stb[1]);
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = 1'b0;
    err_d   = 1'b0;
    if (stb == 2'b11) begin
      err_d = 1'b1;
    end else if (stb != 2'b00) begin
      if (k == PAT_LEN) begin
        out_d   = 1'b1;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        state_d = overlap_en ? c_BORDER : '0;
      end else begin
        state_d = STATE_W'(k);
      end
    end
  end

  always_ff @(posedge clk_100M or posedge clear) begin
    if (clear) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      state_q <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= {input_1, input_0};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign out           = out_q;
  assign err           = err_q;
  assign present_state = state_q;
  assign match_count   = cnt_q;

endmodule

`default_nettype wire
